// File: rtl/hs_fifo_bridge.sv
// Valid/ready elastic buffer: first-word-fall-through FIFO with registered
// handshake outputs, occupancy/almost-full status and a downstream transfer counter.
module hs_fifo_bridge #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 4,
    parameter int AFULL_TH = 3,
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [DATA_W-1:0]            m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full,
    output logic [CNT_W-1:0]             xfer_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_B = $clog2(DEPTH + 1);
    localparam logic [CNT_B-1:0] FULL_C  = CNT_B'(DEPTH);
    localparam logic [CNT_B-1:0] AFULL_C = CNT_B'(AFULL_TH);
    localparam logic [CNT_B-1:0] ONE_C   = CNT_B'(1);
    localparam logic [CNT_B-1:0] ZERO_C  = CNT_B'(0);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_B-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  xfer_cnt_q, xfer_cnt_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              s_ready_q, s_ready_d;
    logic              afull_q, afull_d;
    logic              push_s, pop_s;

    // Next-state for pointers, occupancy, counter and the registered head word.
    always_comb begin
        push_s     = s_valid && s_ready_q;
        pop_s      = m_valid_q && m_ready;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        xfer_cnt_d = xfer_cnt_q;
        m_data_d   = m_data_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
        end else begin
            rd_ptr_d   = rd_ptr_q;
            xfer_cnt_d = xfer_cnt_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
        // The new head is the incoming word whenever the FIFO drains to empty
        // on this edge; otherwise it is already sitting in storage.
        if (count_d == ZERO_C) begin
            m_data_d = '0;
        end else if ((count_q == ZERO_C) || ((count_q == ONE_C) && pop_s)) begin
            m_data_d = s_data;
        end else begin
            m_data_d = mem_q[rd_ptr_d];
        end
        m_valid_d = (count_d != ZERO_C);
        s_ready_d = (count_d != FULL_C);
        afull_d   = (count_d >= AFULL_C);
    end

    // Control and status registers; reset discards all held words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            xfer_cnt_q <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            s_ready_q  <= 1'b1;
            afull_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            xfer_cnt_q <= xfer_cnt_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            s_ready_q  <= s_ready_d;
            afull_q    <= afull_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    assign s_ready     = s_ready_q;
    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign count       = count_q;
    assign almost_full = afull_q;
    assign xfer_cnt    = xfer_cnt_q;

endmodule

// File: tb/tb_hs_fifo_bridge.sv
// Directed and randomised checks of hs_fifo_bridge: default instance plus a
// wide/deep instance with a 4-bit transfer counter.
module tb_hs_fifo_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [15:0] s_data = 16'h0000;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [2:0]  count;
    logic        almost_full;
    logic [15:0] xfer_cnt;

    logic [31:0] s_data2 = 32'h0;
    logic        s_valid2 = 1'b0;
    logic        s_ready2;
    logic [31:0] m_data2;
    logic        m_valid2;
    logic        m_ready2 = 1'b0;
    logic [3:0]  count2;
    logic        almost_full2;
    logic [3:0]  xfer_cnt2;

    int vectors = 0;
    int miscompares = 0;

    always #10 clk = ~clk;

    hs_fifo_bridge dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .count(count), .almost_full(almost_full), .xfer_cnt(xfer_cnt)
    );

    hs_fifo_bridge #(.DATA_W(32), .DEPTH(8), .AFULL_TH(6), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst),
        .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2),
        .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready2),
        .count(count2), .almost_full(almost_full2), .xfer_cnt(xfer_cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        s_valid = 1'b0; m_ready = 1'b0; s_valid2 = 1'b0; m_ready2 = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count); end
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid: got %0b expected 0", m_valid); end
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL reset_s_ready: got %0b expected 1", s_ready); end
        vectors++; if (almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_afull: got %0b expected 0", almost_full); end
        vectors++; if (xfer_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_xfer: got %0d expected 0", xfer_cnt); end
        vectors++; if (m_data !== 16'h0000) begin miscompares++; $display("FAIL reset_m_data: got %0h expected 0", m_data); end
        vectors++; if (m_data2 !== 32'h0) begin miscompares++; $display("FAIL reset_m_data2: got %0h expected 0", m_data2); end
    endtask

    task automatic test_fill();
        logic [2:0] exp_cnt;
        for (int i = 1; i <= 4; i++) begin
            s_data = 16'(i); s_valid = 1'b1;
            tick();
            exp_cnt = 3'(i);
            vectors++; if (count !== exp_cnt) begin miscompares++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, exp_cnt); end
            vectors++; if (almost_full !== (i >= 3)) begin miscompares++; $display("FAIL fill_afull[%0d]: got %0b expected %0b", i, almost_full, (i >= 3)); end
            vectors++; if (s_ready !== (i != 4)) begin miscompares++; $display("FAIL fill_s_ready[%0d]: got %0b expected %0b", i, s_ready, (i != 4)); end
            vectors++; if (m_data !== 16'h0001) begin miscompares++; $display("FAIL fill_m_data[%0d]: got %0h expected 0001", i, m_data); end
        end
        s_data = 16'h0005;
        tick();
        vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL full_hold_count: got %0d expected 4", count); end
        vectors++; if (m_data !== 16'h0001 || m_valid !== 1'b1) begin miscompares++; $display("FAIL full_hold_m_data: got %0h/%0b expected 0001/1", m_data, m_valid); end
    endtask

    task automatic test_drain_from_full();
        logic [15:0] exp_data [5] = '{16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0000};
        logic [2:0]  exp_cnt  [5] = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
        logic        exp_af   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        m_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 1) s_valid = 1'b0;
            vectors++; if (count !== exp_cnt[k]) begin miscompares++; $display("FAIL drain_count[%0d]: got %0d expected %0d", k, count, exp_cnt[k]); end
            vectors++; if (almost_full !== exp_af[k]) begin miscompares++; $display("FAIL drain_afull[%0d]: got %0b expected %0b", k, almost_full, exp_af[k]); end
            vectors++; if (xfer_cnt !== 16'(k + 1)) begin miscompares++; $display("FAIL drain_xfer[%0d]: got %0d expected %0d", k, xfer_cnt, k + 1); end
            if (k < 4) begin
                vectors++; if (m_data !== exp_data[k] || m_valid !== 1'b1) begin miscompares++; $display("FAIL drain_m_data[%0d]: got %0h/%0b expected %0h/1", k, m_data, m_valid, exp_data[k]); end
            end else begin
                vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL drain_empty: got m_valid %0b expected 0", m_valid); end
            end
        end
        m_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        s_valid = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_data = 16'h1000 + 16'(i);
            tick();
            vectors++; if (m_valid !== 1'b1 || m_data !== 16'h1000 + 16'(i)) begin miscompares++; $display("FAIL stream_data[%0d]: got %0h/%0b expected %0h/1", i, m_data, m_valid, 16'h1000 + 16'(i)); end
            vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL stream_count[%0d]: got %0d expected 1", i, count); end
        end
        s_valid = 1'b0;
        tick();
        vectors++; if (xfer_cnt !== 16'd100) begin miscompares++; $display("FAIL stream_xfer: got %0d expected 100", xfer_cnt); end
        vectors++; if (count !== 3'd0 || m_valid !== 1'b0) begin miscompares++; $display("FAIL stream_empty: got %0d/%0b expected 0/0", count, m_valid); end
        m_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] q [$];
        int sent = 0;
        int popped = 0;
        int cycles = 0;
        logic push, pop;
        apply_reset();
        while (popped < 1000 && cycles < 20000) begin
            vectors++; if (count !== 3'(q.size())) begin miscompares++; $display("FAIL rand_count[%0d]: got %0d expected %0d", cycles, count, q.size()); end
            vectors++; if (s_ready !== (q.size() != 4)) begin miscompares++; $display("FAIL rand_s_ready[%0d]: got %0b expected %0b", cycles, s_ready, (q.size() != 4)); end
            vectors++; if (m_valid !== (q.size() != 0)) begin miscompares++; $display("FAIL rand_m_valid[%0d]: got %0b expected %0b", cycles, m_valid, (q.size() != 0)); end
            if (q.size() != 0) begin
                vectors++; if (m_data !== q[0]) begin miscompares++; $display("FAIL rand_m_data[%0d]: got %0h expected %0h", cycles, m_data, q[0]); end
            end
            if (!s_valid && sent < 1000 && $urandom_range(0, 1) == 1) begin
                s_valid = 1'b1;
                s_data  = 16'($urandom);
            end
            m_ready = ($urandom_range(0, 1) == 1);
            push = s_valid && (q.size() != 4);
            pop  = m_ready && (q.size() != 0);
            if (pop) begin
                void'(q.pop_front());
                popped++;
            end
            if (push) begin
                q.push_back(s_data);
                sent++;
            end
            tick();
            if (push) s_valid = 1'b0;
            cycles++;
        end
        vectors++; if (popped != 1000) begin miscompares++; $display("FAIL rand_timeout: got %0d words expected 1000", popped); end
        s_valid = 1'b0; m_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = 16'h0011 + 16'(i);
            tick();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        vectors++; if (count !== 3'd3 || xfer_cnt !== 16'd1 || m_data !== 16'h0012) begin miscompares++; $display("FAIL midrst_pre: got %0d/%0d/%0h expected 3/1/0012", count, xfer_cnt, m_data); end
        #9;
        rst = 1'b1;
        #1;
        vectors++; if (m_valid !== 1'b0 || count !== 3'd0 || xfer_cnt !== 16'd0) begin miscompares++; $display("FAIL midrst_async: got %0b/%0d/%0d expected 0/0/0", m_valid, count, xfer_cnt); end
        vectors++; if (s_ready !== 1'b1 || almost_full !== 1'b0 || m_data !== 16'h0000) begin miscompares++; $display("FAIL midrst_outs: got %0b/%0b/%0h expected 1/0/0000", s_ready, almost_full, m_data); end
        #19;
        rst = 1'b0;
        s_valid = 1'b1; s_data = 16'h0077;
        tick();
        s_valid = 1'b0;
        vectors++; if (m_valid !== 1'b1 || m_data !== 16'h0077 || count !== 3'd1) begin miscompares++; $display("FAIL midrst_first_push: got %0b/%0h/%0d expected 1/0077/1", m_valid, m_data, count); end
        vectors++; if (xfer_cnt !== 16'd0) begin miscompares++; $display("FAIL midrst_xfer: got %0d expected 0", xfer_cnt); end
    endtask

    task automatic test_wide_wrap();
        logic [31:0] w;
        apply_reset();
        s_valid2 = 1'b1; m_ready2 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            w = (i == 0) ? 32'hDEADBEEF : (32'hC0DE0000 + 32'(i));
            s_data2 = w;
            tick();
            vectors++; if (m_valid2 !== 1'b1 || m_data2 !== w) begin miscompares++; $display("FAIL wide_data[%0d]: got %0h/%0b expected %0h/1", i, m_data2, m_valid2, w); end
        end
        vectors++; if (xfer_cnt2 !== 4'd0) begin miscompares++; $display("FAIL wide_xfer16: got %0d expected 0", xfer_cnt2); end
        s_valid2 = 1'b0;
        tick();
        vectors++; if (xfer_cnt2 !== 4'd1) begin miscompares++; $display("FAIL wide_xfer17: got %0d expected 1", xfer_cnt2); end
        vectors++; if (count2 !== 4'd0 || m_valid2 !== 1'b0) begin miscompares++; $display("FAIL wide_empty: got %0d/%0b expected 0/0", count2, m_valid2); end
        m_ready2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain_from_full();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        test_wide_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hs_fifo_bridge.md
Name: hs_fifo_bridge

Overview:
- Parametrised valid/ready elastic buffer between a master (m1-style data source) and a slave (s1-style data sink).
- Next generation of the direct master-to-slave handshake wiring: adds configurable data width, buffer depth, occupancy/almost-full status and a transfer counter.
- Decouples source and sink so that back-pressure from the sink does not stall the source until the buffer is full.
- Sits inline on the data/valid/ready bus, clocked by the 50 MHz system clock.

Parameters:
- DATA_W, 16, payload width in bits (>=1).
- DEPTH, 4, number of entries; power of 2, >=2.
- AFULL_TH, 3, almost_full asserts when count >= AFULL_TH (1..DEPTH).
- CNT_W, 16, width of the xfer_cnt output.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_data  in  DATA_W  payload from the upstream master.
- s_valid  in  1  upstream payload valid.
- s_ready  out  1  bridge can accept a word this cycle.
- m_data  out  DATA_W  payload to the downstream slave.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  downstream accepts m_data this cycle.
- count  out  clog2(DEPTH+1)  number of words held.
- almost_full  out  1  count >= AFULL_TH.
- xfer_cnt  out  CNT_W  number of completed downstream transfers; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, synchronous release on the next clk edge):
  - count = 0, m_valid = 0, s_ready = 1, almost_full = 0, xfer_cnt = 0.
  - m_data = 0.
  - Read and write pointers = 0.
  - Storage contents are don't-care.
- Push: occurs on a clk edge when s_valid && s_ready. s_data is written at wr_ptr; wr_ptr increments mod DEPTH.
- Pop: occurs on a clk edge when m_valid && m_ready. rd_ptr increments mod DEPTH; xfer_cnt increments.
- Output timing:
  - First-word-fall-through.
  - m_data is the entry at rd_ptr and must be stable while m_valid && !m_ready.
  - m_valid = (count != 0).
- Latency: a word pushed into an empty bridge appears with m_valid = 1 on the cycle after the push edge. There is no combinational s->m bypass.
- s_ready = (count != DEPTH).
  - Depends only on registered state; there is no combinational path from m_ready to s_ready.
  - When full, a pop in the same cycle does not enable a push; the push is accepted on the following cycle.
- Count update per edge:
  - Push only: +1.
  - Pop only: -1.
  - Both: unchanged, with pointers both advancing.
  - Neither: unchanged.
- Simultaneous push and pop when count = 1: the popped word leaves, and the new word becomes m_data on the next cycle with m_valid held at 1.
- Upstream protocol: once s_valid is raised it must stay high with s_data stable until accepted. The bridge does not rely on this property but is verified under it.
- almost_full: combinational decode of count, or registered alongside count; it must match count >= AFULL_TH in the same cycle.
- Pointer wrap: pointers are clog2(DEPTH) bits wide; the full/empty distinction comes from count, not from pointer compare.
- Reset mid-operation: all held words are discarded immediately and outputs go to their reset values asynchronously. No transfer completes on the edge where rst is high.
- Data order: strict FIFO; no loss or duplication.

Test Plan:
- Reset, then drive s_valid=1, s_data=16'h0001..16'h0004 on consecutive cycles with m_ready=0 -> s_ready goes low after the 4th push; count=4; almost_full high from count=3; m_data=16'h0001 held stable.
- From full, set m_ready=1 while s_valid=1 with s_data=16'h0005 -> 0001..0004 emerge on four consecutive cycles; 0005 is accepted the cycle after the first pop; xfer_cnt=4 after four pops.
- Streaming with s_valid=1 and m_ready=1 continuously, 100 words (incrementing pattern) -> after a 1-cycle initial latency, one word out per cycle in order; count stays at 1; xfer_cnt=100.
- Random s_valid and m_ready at 50% each, 1000 words -> scoreboard shows in-order, lossless delivery; count never exceeds 4; s_ready=0 exactly when count=4.
- Assert rst for 1 cycle at mid-clock with count=3 -> m_valid, count and xfer_cnt go to 0 immediately; the first post-reset push reappears after 1 cycle.
- With CNT_W=4, perform 17 transfers -> xfer_cnt wraps to 1; with DATA_W=32 and DEPTH=8, data 32'hDEADBEEF passes through intact.
